// File: rtl/tx_pkt_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tx_pkt_sequencer_pkg
// Description : Shared state encoding and framing constants for the TX
//               packet sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package tx_pkt_sequencer_pkg;

  // Framing state encoding
  localparam logic [1:0] C_ST_IDLE = 2'b00;
  localparam logic [1:0] C_ST_PRE  = 2'b01;
  localparam logic [1:0] C_ST_DATA = 2'b10;
  localparam logic [1:0] C_ST_GAP  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = C_ST_IDLE,
    PRE  = C_ST_PRE,
    DATA = C_ST_DATA,
    GAP  = C_ST_GAP
  } state_t;

  // Preamble byte sent ahead of every payload
  localparam logic [7:0] C_DEFAULT_PREAMBLE = 8'hAA;

endpackage
`default_nettype wire

// File: rtl/tx_pkt_sequencer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tx_byte_fifo
// Description : Synchronous byte FIFO with push, pop, flush and level/full/
//               empty status. Head byte is presented combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_level == C_FULL_LVL);
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign dout      = r_mem[r_rd_ptr];
  // A push into a full FIFO is dropped; a pop of an empty FIFO is ignored
  assign w_do_push = push && !full && !flush;
  assign w_do_pop  = pop && !empty && !flush;

  // Storage array; write at the tail pointer
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/tx_pkt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tx_pkt_sequencer
// Description : Buffers SPI bytes and serialises complete packets (preamble
//               + payload, MSB first) onto tx_bit with a programmable bit
//               period, followed by a one-bit inter-packet gap.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_pkt_sequencer
  import tx_pkt_sequencer_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter int         PKT_BYTES = 3,
  parameter logic [7:0] PREAMBLE  = C_DEFAULT_PREAMBLE,
  parameter int         BP_W      = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tx_en,
  input  logic [7:0]               spi_byte,
  input  logic                     spi_valid,
  input  logic [BP_W-1:0]          bit_period,
  output logic                     tx_bit,
  output logic                     tx_active,
  output logic                     pkt_done,
  output logic                     abort,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(PKT_BYTES + 1);
  localparam logic [LW-1:0] C_PKT_LVL = LW'(PKT_BYTES);
  localparam logic [BW-1:0] C_PKT_CNT = BW'(PKT_BYTES);

  state_t          r_state,    w_nxt_state;
  logic [BP_W-1:0] r_bp_q,     w_nxt_bp_q;
  logic [BP_W-1:0] r_cnt,      w_nxt_cnt;
  logic [2:0]      r_bit_cnt,  w_nxt_bit_cnt;
  logic [BW-1:0]   r_byte_cnt, w_nxt_byte_cnt;
  logic [7:0]      r_shift,    w_nxt_shift;
  logic            r_tx_bit,   w_nxt_tx_bit;
  logic            r_active,   w_nxt_active;
  logic            r_abort,    w_nxt_abort;
  logic            r_overflow;
  logic            r_tx_en_d;

  logic            w_fall;
  logic            w_term;
  logic            w_pop;
  logic [7:0]      w_head;
  logic [LW-1:0]   w_level;
  logic            w_full;
  logic            w_empty;

  // tx_en falling edge: aborts an active packet and flushes the buffer
  assign w_fall = r_tx_en_d && !tx_en;
  assign w_term = (r_cnt == r_bp_q - 1'b1);

  tx_byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (spi_valid && !w_fall),
    .pop   (w_pop),
    .flush (w_fall),
    .din   (spi_byte),
    .dout  (w_head),
    .level (w_level),
    .full  (w_full),
    .empty (w_empty)
  );

  assign tx_bit     = r_tx_bit;
  assign tx_active  = r_active;
  assign abort      = r_abort;
  assign fifo_level = w_level;
  assign overflow   = r_overflow;
  // Decoded from registers so it lands on the final gap cycle
  assign pkt_done   = (r_state == GAP) && w_term;

  // Framing state, bit timing and shift register update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_bp_q     <= '0;
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_tx_bit   <= 1'b0;
      r_active   <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_bp_q     <= w_nxt_bp_q;
      r_cnt      <= w_nxt_cnt;
      r_bit_cnt  <= w_nxt_bit_cnt;
      r_byte_cnt <= w_nxt_byte_cnt;
      r_shift    <= w_nxt_shift;
      r_tx_bit   <= w_nxt_tx_bit;
      r_active   <= w_nxt_active;
      r_abort    <= w_nxt_abort;
    end
  end

  // Sticky overflow and tx_en edge history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
      r_tx_en_d  <= 1'b0;
    end else begin
      r_tx_en_d <= tx_en;
      if (w_fall) begin
        r_overflow <= 1'b0;
      end else if (spi_valid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Next-state and datapath decode for the framing FSM
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_bp_q     = r_bp_q;
    w_nxt_cnt      = r_cnt;
    w_nxt_bit_cnt  = r_bit_cnt;
    w_nxt_byte_cnt = r_byte_cnt;
    w_nxt_shift    = r_shift;
    w_nxt_tx_bit   = r_tx_bit;
    w_nxt_active   = r_active;
    w_nxt_abort    = 1'b0;
    w_pop          = 1'b0;

    if (w_fall && (r_state != IDLE)) begin
      w_nxt_state    = IDLE;
      w_nxt_tx_bit   = 1'b0;
      w_nxt_active   = 1'b0;
      w_nxt_abort    = 1'b1;
      w_nxt_cnt      = '0;
      w_nxt_bit_cnt  = '0;
      w_nxt_byte_cnt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_nxt_tx_bit = 1'b0;
          w_nxt_active = 1'b0;
          if (tx_en && (w_level >= C_PKT_LVL)) begin
            w_nxt_state    = PRE;
            w_nxt_bp_q     = (bit_period == '0) ? BP_W'(1) : bit_period;
            w_nxt_shift    = PREAMBLE;
            w_nxt_tx_bit   = PREAMBLE[7];
            w_nxt_active   = 1'b1;
            w_nxt_cnt      = '0;
            w_nxt_bit_cnt  = '0;
            w_nxt_byte_cnt = '0;
          end
        end
        PRE, DATA: begin
          if (w_term) begin
            w_nxt_cnt = '0;
            if (r_bit_cnt == 3'd7) begin
              w_nxt_bit_cnt = '0;
              // Next payload byte follows the previous last bit directly
              if ((r_state == PRE) || (r_byte_cnt < C_PKT_CNT)) begin
                w_pop          = !w_empty;
                w_nxt_shift    = w_head;
                w_nxt_tx_bit   = w_head[7];
                w_nxt_byte_cnt = r_byte_cnt + 1'b1;
                w_nxt_state    = DATA;
              end else begin
                w_nxt_tx_bit = 1'b0;
                w_nxt_state  = GAP;
              end
            end else begin
              w_nxt_bit_cnt = r_bit_cnt + 1'b1;
              w_nxt_shift   = {r_shift[6:0], 1'b0};
              w_nxt_tx_bit  = r_shift[6];
            end
          end else begin
            w_nxt_cnt = r_cnt + 1'b1;
          end
        end
        GAP: begin
          w_nxt_tx_bit = 1'b0;
          if (w_term) begin
            w_nxt_cnt    = '0;
            w_nxt_active = 1'b0;
            w_nxt_state  = IDLE;
          end else begin
            w_nxt_cnt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_nxt_state = IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
